// File: rtl/time_set_pkg.sv
// Shared state encoding, BCD limits and BCD increment helper for the time-set controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Two-digit BCD increment; anything at or above the limit wraps to 00, a stray low digit carries.
  function automatic logic [7:0] bcdInc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val >= max)
      res = 8'h00;
    else if (val[3:0] >= 4'd9)
      res = {val[7:4] + 4'd1, 4'h0};
    else
      res = {val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchronizer, counting debouncer and single-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic          stableDly_q, stableDly_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] debCnt_q, debCnt_d;
  logic [CW-1:0] armCnt_q, armCnt_d;
  logic          sample;

  assign sample = sync_q[1];

  // Presses only count once a released level has been seen for a full debounce window,
  // so a key held across reset stays silent until it is released and pressed again.
  always_comb begin
    sync_d      = {sync_q[0], key_i};
    stableDly_d = stable_q;
    stable_d    = stable_q;
    debCnt_d    = '0;
    if (sample != stable_q) begin
      if (debCnt_q == CNT_LAST)
        stable_d = sample;
      else
        debCnt_d = debCnt_q + CW'(1);
    end
    armed_d  = armed_q;
    armCnt_d = '0;
    if (!armed_q && sample) begin
      if (armCnt_q == CNT_LAST)
        armed_d = 1'b1;
      else
        armCnt_d = armCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      stable_q    <= 1'b1;
      stableDly_q <= 1'b1;
      armed_q     <= 1'b0;
      debCnt_q    <= '0;
      armCnt_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      stable_q    <= stable_d;
      stableDly_q <= stableDly_d;
      armed_q     <= armed_d;
      debCnt_q    <= debCnt_d;
      armCnt_q    <= armCnt_d;
    end
  end

  assign press_o = armed_q & stableDly_q & ~stable_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: RUN / SET_HOUR / SET_MIN with BCD shadow registers and a load pulse.
// Optional digit blinking while setting is enabled by defining TIME_SET_BLINK_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_mode,
  input  logic       i_key_inc,
  input  logic [3:0] i_hour1,
  input  logic [3:0] i_hour0,
  input  logic [3:0] i_min1,
  input  logic [3:0] i_min0,
  output logic       o_run,
  output logic       o_load,
  output logic [3:0] o_hour1,
  output logic [3:0] o_hour0,
  output logic [3:0] o_min1,
  output logic [3:0] o_min0,
  output logic [3:0] o_blank
);

  if (DEB_CYCLES < 1 || BLINK_HALF < 1) begin : g_param_check
    $error("time_set_ctrl: DEB_CYCLES and BLINK_HALF must be positive");
  end

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic       load_q, load_d;
  logic       modeEv, incEv;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_i   (i_key_mode),
    .press_o (modeEv)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_inc (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_i   (i_key_inc),
    .press_o (incEv)
  );

  // Mode is checked before inc so a simultaneous inc is dropped.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    load_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (modeEv) begin
          state_d = SET_HOUR;
          hour_d  = {i_hour1, i_hour0};
          min_d   = {i_min1, i_min0};
        end
      end
      SET_HOUR: begin
        if (modeEv)
          state_d = SET_MIN;
        else if (incEv)
          hour_d = bcdInc(hour_q, HOUR_MAX);
      end
      SET_MIN: begin
        if (modeEv) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (incEv) begin
          min_d = bcdInc(min_q, MIN_MAX);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      load_q  <= load_d;
    end
  end

  assign o_run   = (state_q == RUN);
  assign o_load  = load_q;
  assign o_hour1 = hour_q[7:4];
  assign o_hour0 = hour_q[3:0];
  assign o_min1  = min_q[7:4];
  assign o_min0  = min_q[3:0];

`ifdef TIME_SET_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          phase_q, phase_d;

  // Any state change restarts the blink with the digits visible.
  always_comb begin
    blinkCnt_d = blinkCnt_q + BW'(1);
    phase_d    = phase_q;
    if (state_d != state_q) begin
      blinkCnt_d = '0;
      phase_d    = 1'b1;
    end else if (blinkCnt_q == BLINK_LAST) begin
      blinkCnt_d = '0;
      phase_d    = ~phase_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blinkCnt_q <= '0;
      phase_q    <= 1'b1;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    o_blank = 4'b0000;
    if (!phase_q) begin
      if (state_q == SET_HOUR)
        o_blank = 4'b1100;
      else if (state_q == SET_MIN)
        o_blank = 4'b0011;
    end
  end
`else
  assign o_blank = 4'b0000;
`endif

endmodule
